// File: rtl/multiprec_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// Sequencer state encoding, add/sub mode encodings, limb counter sizing.
package multiprec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Keep at least one counter bit so a degenerate LIMBS still elaborates.
    function automatic int cnt_w(input int limbs);
        return (limbs > 1) ? $clog2(limbs) : 1;
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Narrow adder-subtractor: sum = a + (b ^ {sub}) + (cin ^ sub).
// Purely combinational, zero latency; no flow control.
// In subtract mode cin=0 gives a plain a - b.
module adder_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_total;

    assign w_b_eff = i_b ^ {WIDTH{i_sub}};
    assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin ^ i_sub};
    assign o_sum   = w_total[WIDTH-1:0];
    assign o_cout  = w_total[WIDTH];
    assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/multiprec_addsub_seq.sv
// Wide add/subtract over one shared LIMB_W adder, LSB limb first; MULTIPREC_ZERO_FLAG_EN adds a zero flag.
// Latency: start at edge T -> busy T+1..T+LIMBS -> done pulse at T+LIMBS+1.
// No backpressure: start is only accepted in IDLE/DONE and ignored while busy.
module multiprec_addsub_seq
    import multiprec_pkg::*;
#(
    parameter int LIMB_W = 8,
    parameter int LIMBS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [LIMB_W*LIMBS-1:0] a,
    input  logic [LIMB_W*LIMBS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [LIMB_W*LIMBS-1:0] result,
    output logic                cout,
    output logic                overflow
`ifdef MULTIPREC_ZERO_FLAG_EN
    ,
    output logic                zero
`endif
);

    localparam int N  = LIMB_W * LIMBS;
    localparam int CW = cnt_w(LIMBS);

    state_t              r_state, w_state_nxt;
    logic [N-1:0]        r_a, r_b, r_result;
    logic [N-LIMB_W-1:0] r_work;
    logic                r_mode, r_carry, r_cout, r_ovf;
    logic [CW-1:0]       r_idx;

    logic [LIMB_W-1:0]   w_a_limb, w_b_limb, w_sum;
    logic                w_cout, w_limb_ovf, w_accept, w_last, w_ovf_full;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_idx == CW'(LIMBS - 1));
    assign w_a_limb = r_a[int'(r_idx)*LIMB_W +: LIMB_W];
    assign w_b_limb = r_b[int'(r_idx)*LIMB_W +: LIMB_W];

    adder_subtractor #(.WIDTH(LIMB_W)) u_limb_alu (
        .i_a    (w_a_limb),
        .i_b    (w_b_limb),
        .i_sub  (r_mode),
        .i_cin  (r_carry ^ r_mode),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_limb_ovf)
    );

    // Full-width signed overflow only depends on the MS limb's sign bits.
    assign w_ovf_full = (r_a[N-1] == (r_b[N-1] ^ r_mode)) && (w_sum[LIMB_W-1] != r_a[N-1]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef MULTIPREC_ZERO_FLAG_EN
    logic r_zacc, r_zero;
    assign zero = r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_ADD;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef MULTIPREC_ZERO_FLAG_EN
            r_zacc   <= 1'b0;
            r_zero   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= mode;
            r_idx   <= '0;
`ifdef MULTIPREC_ZERO_FLAG_EN
            r_zacc  <= 1'b1;
`endif
        end else if (r_state == RUN) begin
            r_carry <= w_cout;
`ifdef MULTIPREC_ZERO_FLAG_EN
            r_zacc  <= r_zacc & (w_sum == '0);
`endif
            if (w_last) begin
                // Publish results only here so idle outputs never show partial sums.
                r_result <= {w_sum, r_work};
                r_cout   <= w_cout;
                r_ovf    <= w_ovf_full;
`ifdef MULTIPREC_ZERO_FLAG_EN
                r_zero   <= r_zacc & (w_sum == '0);
`endif
            end else begin
                r_work[int'(r_idx)*LIMB_W +: LIMB_W] <= w_sum;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

    a_ovf_consistent: assert property (@(posedge clk) disable iff (rst)
        (r_state == RUN && w_last) |-> (w_ovf_full == w_limb_ovf));

endmodule

// File: tb/tb_multiprec_addsub_seq.sv
// Directed self-checking bench for multiprec_addsub_seq (LIMB_W=8, LIMBS=4).
// Expected values are hand-computed constants.
module tb_multiprec_addsub_seq;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [31:0] a, b, result;
    logic        busy, done, cout, overflow;
    logic        zero;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multiprec_addsub_seq #(.LIMB_W(8), .LIMBS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
`ifdef MULTIPREC_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

`ifndef MULTIPREC_ZERO_FLAG_EN
    assign zero = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from mid-cycle; returns in the cycle where done must be high.
    task automatic run_op(input logic m, input logic [31:0] op_a, input logic [31:0] op_b);
        start = 1'b1; mode = m; a = op_a; b = op_b;
        tick();
        start = 1'b0; mode = ~m; a = 32'hDEAD_BEEF; b = 32'h5A5A_A5A5;
        for (int k = 1; k <= 4; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            if (k < 4) tick();
        end
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic chk_res(input logic [31:0] r, input logic c, input logic v);
        chk("result", result, r);
        chk("cout", 32'(cout), 32'(c));
        chk("overflow", 32'(overflow), 32'(v));
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_res(32'h0, 1'b0, 1'b0);
`ifdef MULTIPREC_ZERO_FLAG_EN
        chk("rst_zero", 32'(zero), 32'd0);
`endif

        // 1: carry ripples across limb boundary
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001);
        chk_res(32'h0000_0100, 1'b0, 1'b0);
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_hold", result, 32'h0000_0100);

        // 2: subtraction with and without borrow
        run_op(1'b1, 32'h0000_0000, 32'h0000_0001);
        chk_res(32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        run_op(1'b1, 32'h0000_0005, 32'h0000_0003);
        chk_res(32'h0000_0002, 1'b1, 1'b0);
        tick();

        // 3: signed overflow both directions
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        chk_res(32'h8000_0000, 1'b0, 1'b1);
        tick();
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001);
        chk_res(32'h7FFF_FFFF, 1'b1, 1'b1);
        tick();

        // 4: full wrap to zero
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk_res(32'h0000_0000, 1'b1, 1'b0);
`ifdef MULTIPREC_ZERO_FLAG_EN
        chk("zero_set", 32'(zero), 32'd1);
`endif
        tick();
        run_op(1'b0, 32'h0000_0001, 32'h0000_0001);
        chk_res(32'h0000_0002, 1'b0, 1'b0);
`ifdef MULTIPREC_ZERO_FLAG_EN
        chk("zero_clr", 32'(zero), 32'd0);
`endif
        tick();

        // 5: start during RUN ignored; start in DONE accepted back-to-back
        start = 1'b1; mode = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("b2b_done1", 32'(done), 32'd1);
        chk_res(32'h0000_0030, 1'b0, 1'b0);
        start = 1'b1; mode = 1'b1; a = 32'h0000_0100; b = 32'h0000_0001;
        tick();
        start = 1'b0; a = 32'hCAFE_F00D; b = 32'h0BAD_0BAD; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_hold", result, 32'h0000_0030);
            tick();
        end
        chk("b2b_done2", 32'(done), 32'd1);
        chk_res(32'h0000_00FF, 1'b1, 1'b0);
        tick();

        // 6: reset mid-operation aborts with no done pulse
        start = 1'b1; mode = 1'b0; a = 32'h0000_0003; b = 32'h0000_0004;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk_res(32'h0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort_nodone", 32'(pulses), 32'd0);
        run_op(1'b0, 32'h1234_5678, 32'h1111_1111);
        chk_res(32'h2345_6789, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
